// File: rtl/sprite_fetch.sv
`default_nettype none
// ============================================================================
// Module      : sprite_fetch
// Description : Streams a fixed-size sprite from a registered ROM and
//               composites it over the background raster with a colour key.
//               Two-cycle pipeline, one pixel per clock.
// Revision    : 1.0 - initial release
// ============================================================================
module sprite_fetch #(
    parameter int          SPR_W   = 181,
    parameter int          SPR_H   = 256,
    parameter logic [23:0] KEY_RGB = 24'h000000
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        frame_start,
    input  logic        de,
    input  logic [9:0]  DrawX,
    input  logic [9:0]  DrawY,
    input  logic [9:0]  SpriteX,
    input  logic [9:0]  SpriteY,
    input  logic        sprite_en,
    input  logic [23:0] bg_rgb,
    output logic [16:0] read_address,
    input  logic [23:0] rom_data,
    output logic [23:0] pix_rgb,
    output logic        pix_hit,
    output logic        pix_de
);

    // Largest top-left corner that still keeps the whole sprite on screen.
    localparam logic [10:0] c_MAX_X     = 11'(640 - SPR_W);
    localparam logic [10:0] c_MAX_Y     = 11'(480 - SPR_H);
    localparam logic [10:0] c_SPR_W     = 11'(SPR_W);
    localparam logic [10:0] c_SPR_H     = 11'(SPR_H);
    localparam logic [16:0] c_LAST_ADDR = 17'(SPR_W * SPR_H - 1);

    // Latched per-frame sprite placement.
    logic [10:0] r_pos_x;
    logic [10:0] r_pos_y;
    logic        r_en;

    // Texel address counter; raster order turns it into y*SPR_W+x for free.
    logic [16:0] r_addr;

    // Stage 1 (aligned with rom_data).
    logic        r_inside_d;
    logic        r_de_d;
    logic [23:0] r_bg_d;

    // Stage 2 outputs.
    logic [23:0] r_pix_rgb;
    logic        r_pix_hit;
    logic        r_pix_de;

    logic [10:0] w_clamp_x;
    logic [10:0] w_clamp_y;
    logic [10:0] w_x_end;
    logic [10:0] w_y_end;
    logic [10:0] w_draw_x;
    logic [10:0] w_draw_y;
    logic        w_inside;
    logic        w_hit;

    // Clamp requested position so the sprite never leaves the screen.
    assign w_clamp_x = ({1'b0, SpriteX} > c_MAX_X) ? c_MAX_X : {1'b0, SpriteX};
    assign w_clamp_y = ({1'b0, SpriteY} > c_MAX_Y) ? c_MAX_Y : {1'b0, SpriteY};

    // 11-bit window compare: pos+size reaches 640/480 without wrapping.
    assign w_x_end  = r_pos_x + c_SPR_W;
    assign w_y_end  = r_pos_y + c_SPR_H;
    assign w_draw_x = {1'b0, DrawX};
    assign w_draw_y = {1'b0, DrawY};
    assign w_inside = de && r_en
                      && (w_draw_x >= r_pos_x) && (w_draw_x < w_x_end)
                      && (w_draw_y >= r_pos_y) && (w_draw_y < w_y_end);

    // Opaque texel test on the ROM word that belongs to the stage-1 pixel.
    assign w_hit = r_de_d && r_inside_d && (rom_data != KEY_RGB);

    // Latch sprite placement and enable once per frame.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_pos_x <= '0;
            r_pos_y <= '0;
            r_en    <= 1'b0;
        end else if (frame_start) begin
            r_pos_x <= w_clamp_x;
            r_pos_y <= w_clamp_y;
            r_en    <= sprite_en;
        end
    end

    // Address counter: restart on frame_start, advance on inside, saturate at last texel.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_addr <= '0;
        end else if (frame_start) begin
            r_addr <= '0;
        end else if (w_inside && (r_addr != c_LAST_ADDR)) begin
            r_addr <= r_addr + 17'd1;
        end
    end

    // Stage 1: delay raster qualifiers to meet the ROM's one-cycle latency.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_inside_d <= 1'b0;
            r_de_d     <= 1'b0;
            r_bg_d     <= '0;
        end else begin
            r_inside_d <= w_inside;
            r_de_d     <= de;
            r_bg_d     <= bg_rgb;
        end
    end

    // Stage 2: composite sprite over background; blank outside the visible area.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_pix_rgb <= '0;
            r_pix_hit <= 1'b0;
            r_pix_de  <= 1'b0;
        end else begin
            r_pix_de  <= r_de_d;
            r_pix_hit <= w_hit;
            if (!r_de_d) begin
                r_pix_rgb <= '0;
            end else if (w_hit) begin
                r_pix_rgb <= rom_data;
            end else begin
                r_pix_rgb <= r_bg_d;
            end
        end
    end

    assign read_address = r_addr;
    assign pix_rgb      = r_pix_rgb;
    assign pix_hit      = r_pix_hit;
    assign pix_de       = r_pix_de;

endmodule
`default_nettype wire

// File: doc/sprite_fetch.md
SPRITE_FETCH -- requirements
Module: sprite_fetch

Interface
REQ-001 SHALL have parameter SPR_W, default 181: sprite width in pixels.
REQ-002 SHALL have parameter SPR_H, default 256: sprite height in pixels; SPR_W*SPR_H SHALL be at most 131072.
REQ-003 SHALL have parameter KEY_RGB, default 24'h000000: transparent colour key.
REQ-004 Clk  in  1: single clock; all state on rising edge.
REQ-005 Reset  in  1: asynchronous, active-high reset.
REQ-006 frame_start  in  1: one-cycle pulse before the first visible pixel of each frame.
REQ-007 de  in  1: display enable; 1 while DrawX/DrawY is a visible pixel (640x480).
REQ-008 DrawX, DrawY  in  10 each: current raster coordinate, raster order.
REQ-009 SpriteX, SpriteY  in  10 each: requested sprite top-left position.
REQ-010 sprite_en  in  1: sprite visible this frame when 1.
REQ-011 bg_rgb  in  24: background colour for the current DrawX/DrawY.
REQ-012 read_address  out  17: sprite ROM address; the ROM registers it, giving 1-cycle latency.
REQ-013 rom_data  in  24: ROM palette output, valid one cycle after read_address.
REQ-014 pix_rgb  out  24: composited pixel, registered.
REQ-015 pix_hit  out  1: 1 when pix_rgb came from an opaque sprite texel.
REQ-016 pix_de  out  1: de delayed to align with pix_rgb.

Function
REQ-017 On frame_start, SHALL latch pos_x = min(SpriteX, 640-SPR_W) and pos_y = min(SpriteY, 480-SPR_H).
- The sprite is always fully on screen.
- Defaults: 459 and 224.
REQ-018 On frame_start, SHALL also latch en_l = sprite_en and clear addr_cnt to 0.
- Changes to SpriteX, SpriteY or sprite_en mid-frame SHALL have no effect until the next frame_start.
REQ-019 SHALL compute inside combinationally as de & en_l & (pos_x <= DrawX < pos_x+SPR_W) & (pos_y <= DrawY < pos_y+SPR_H).
- Comparisons are 11-bit unsigned, so there is no wrap.
REQ-020 read_address SHALL equal addr_cnt, a registered 17-bit counter.
REQ-021 addr_cnt SHALL increment by 1 on each cycle inside=1 and hold otherwise.
- Raster order makes addr_cnt equal (DrawY-pos_y)*SPR_W + (DrawX-pos_x); no multiplier SHALL be used.
REQ-022 addr_cnt SHALL saturate at SPR_W*SPR_H-1 and never wrap within a frame.
REQ-023 If frame_start and inside are both 1 in the same cycle, frame_start SHALL win: addr_cnt=0 and the new position is latched.
REQ-024 Stage 1 (t+1) SHALL register inside_d, de_d and bg_d from cycle t; rom_data for cycle t is valid at t+1.
REQ-025 Stage 2 (t+2) SHALL register the outputs:
- pix_hit = inside_d & (rom_data != KEY_RGB)
- pix_rgb = pix_hit ? rom_data : bg_d
- pix_de = de_d
REQ-026 Total latency from DrawX/DrawY/de/bg_rgb to pix_* SHALL be exactly 2 cycles with no throughput gaps (one pixel per cycle).
REQ-027 When de_d=0, pix_rgb SHALL be 24'h000000 and pix_hit SHALL be 0.

Reset
REQ-028 While Reset=1, asynchronously, the following SHALL be 0: addr_cnt, read_address, pos_x, pos_y, en_l, inside_d, de_d, bg_d, pix_rgb, pix_hit, pix_de.
REQ-029 After Reset is released, the sprite SHALL stay hidden (en_l=0) until the first frame_start.
REQ-030 Reset asserted mid-frame SHALL abort the frame with no residual address state.

Verification
REQ-031 Sprite at SpriteX=100, SpriteY=50, full frame:
- At DrawX=100, DrawY=50: read_address=0.
- At DrawX=280, DrawY=50: read_address=180.
- At DrawX=100, DrawY=51: read_address=181.
- At DrawX=280, DrawY=305: read_address=46335.
REQ-032 rom_data=24'h3f3539 at an inside pixel, bg_rgb=24'h0000ff:
- Two cycles later pix_rgb=24'h3f3539 and pix_hit=1.
- With rom_data=24'h000000 instead: pix_rgb=24'h0000ff and pix_hit=0.
REQ-033 SpriteX=600, SpriteY=400 at frame_start: latched pos_x=459, pos_y=224; the last texel read is at DrawX=639, DrawY=479 with address 46335.
REQ-034 SpriteX changed from 100 to 300 mid-frame: the current frame still draws at x=100; the next frame draws at x=300; read_address restarts at 0.
REQ-035 sprite_en=0 at frame_start: read_address stays 0, pix_hit=0 all frame, pix_rgb=bg_rgb delayed 2 cycles.
REQ-036 Reset pulsed at DrawY=100 inside the sprite: all outputs go to 0 immediately; no hits until after the next frame_start with sprite_en=1.
